ecc_decoder: RTL and testbench

Pipelined single-error-correct / double-error-detect decoder sitting directly downstream of the encoder stage on the codeword path. Accepts right-aligned 8/16/32-bit codewords, computes the syndrome, corrects a single flipped bit, flags double errors, and returns right-aligned, zero-padded data. Valid/ready handshakes on both sides; saturating error-statistics counters are exposed to the register block.

---
 rtl/ecc_pkg.sv | 93 +++++++++
 rtl/ecc_syndrome.sv | 24 ++
 rtl/ecc_decoder.sv | 153 +++++++++++++++
 tb/tb_ecc_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: definitions shared by the SEC-DED encoder, decoder and bench model.
//   - codeword width codes and (n, k, p) per width
//   - parity-check matrices H_SMALL / H_MEDIUM / H_LARGE, stored one column per
//     codeword bit (column j is the syndrome contribution of bit j)
//   - helpers selecting H, the codeword mask, the data mask and p by width code
// H construction: every column has bit 0 set (row 0 = overall parity), and the
// upper p-1 bits enumerate all 2^(p-1) values exactly once. Parity bit 0 takes
// upper value 0, parity bit i takes upper value 1<<(i-1), so the parity columns
// are independent and the encoder solves them directly. Data bits take the
// remaining values in increasing order.
package ecc_pkg;

   localparam int WORD_W = 32;
   localparam int P_MAX  = 6;

   typedef enum logic [1:0] {
      WC_SMALL     = 2'b00,
      WC_MEDIUM    = 2'b01,
      WC_LARGE     = 2'b10,
      WC_LARGE_ALT = 2'b11
   } width_code_e;

   localparam int N_SMALL  = 8;
   localparam int K_SMALL  = 4;
   localparam int P_SMALL  = 4;
   localparam int N_MEDIUM = 16;
   localparam int K_MEDIUM = 11;
   localparam int P_MEDIUM = 5;
   localparam int N_LARGE  = 32;
   localparam int K_LARGE  = 26;
   localparam int P_LARGE  = 6;

   localparam logic [1:0] NERR_NONE = 2'd0;
   localparam logic [1:0] NERR_ONE  = 2'd1;
   localparam logic [1:0] NERR_TWO  = 2'd2;

   typedef logic [WORD_W-1:0][P_MAX-1:0] hmat_t;

   function automatic hmat_t build_h(input int p);
      hmat_t h;
      int    j;
      h = '0;
      j = p;
      h[0] = 6'd1;
      for (int i = 1; i < p; i++) begin
         h[5'(i)] = 6'(1 | (1 << i));
      end
      for (int v = 0; v < WORD_W; v++) begin
         if (v < (1 << (p - 1)) && v != 0 && (v & (v - 1)) != 0) begin
            h[5'(j)] = 6'((v << 1) | 1);
            j++;
         end
      end
      return h;
   endfunction

   localparam hmat_t H_SMALL  = build_h(P_SMALL);
   localparam hmat_t H_MEDIUM = build_h(P_MEDIUM);
   localparam hmat_t H_LARGE  = build_h(P_LARGE);

   function automatic hmat_t h_for(input logic [1:0] wc);
      case (wc)
         WC_SMALL:  return H_SMALL;
         WC_MEDIUM: return H_MEDIUM;
         default:   return H_LARGE;
      endcase
   endfunction

   function automatic int cw_p(input logic [1:0] wc);
      case (wc)
         WC_SMALL:  return P_SMALL;
         WC_MEDIUM: return P_MEDIUM;
         default:   return P_LARGE;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] cw_mask(input logic [1:0] wc);
      case (wc)
         WC_SMALL:  return 32'h0000_00FF;
         WC_MEDIUM: return 32'h0000_FFFF;
         default:   return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] data_mask(input logic [1:0] wc);
      case (wc)
         WC_SMALL:  return 32'h0000_000F;
         WC_MEDIUM: return 32'h0000_07FF;
         default:   return 32'h03FF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome of a right-aligned, already masked
// codeword using the H matrix selected by the width code.
//   cw    in  WORD_W  masked codeword (bits above n are zero)
//   width in  2       width code, 11 treated as large
//   syn   out P_MAX   syndrome, bits above p are zero
module ecc_syndrome
   import ecc_pkg::*;
(
   input  logic [WORD_W-1:0] cw,
   input  logic [1:0]        width,
   output logic [P_MAX-1:0]  syn
);

   hmat_t h;

   always_comb begin
      h   = h_for(width);
      syn = '0;
      for (int j = 0; j < WORD_W; j++) begin
         if (cw[j]) syn = syn ^ h[j];
      end
   end

endmodule

// File: rtl/ecc_decoder.sv
// ecc_decoder: two-stage SEC-DED decoder with valid/ready on both sides.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake; in_ready is combinational from
//                             out_ready and the stage valids
//   CODEWORD_IN/WIDTH         right-aligned codeword and its width code
//   out_valid/out_ready       output handshake, outputs held while stalled
//   DATA_OUT/NUM_OF_ERRORS    right-aligned zero-padded data, 0/1/2 errors
//   cnt_clear                 clears both counters, wins over an increment
//   err_cnt_single/double     saturating counts of delivered 1/2-error results
module ecc_decoder
   import ecc_pkg::*;
#(
   parameter int AMBA_WORD = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AMBA_WORD-1:0] CODEWORD_IN,
   input  logic [1:0]           CODEWORD_WIDTH,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AMBA_WORD-1:0] DATA_OUT,
   output logic [1:0]           NUM_OF_ERRORS,
   input  logic                 cnt_clear,
   output logic [CNT_WIDTH-1:0] err_cnt_single,
   output logic [CNT_WIDTH-1:0] err_cnt_double
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                 s1_load, s2_load, fire;
   logic [WORD_W-1:0]    cw_in;
   logic [P_MAX-1:0]     syn_in;

   logic                 vld_p1_q, vld_p1_d;
   logic [WORD_W-1:0]    cw_p1_q, cw_p1_d;
   logic [1:0]           width_p1_q, width_p1_d;
   logic [P_MAX-1:0]     syn_p1_q, syn_p1_d;

   hmat_t                h_p1;
   logic [WORD_W-1:0]    fixed_cw, corr_data;
   logic [1:0]           corr_nerr;

   logic                 vld_p2_q, vld_p2_d;
   logic [AMBA_WORD-1:0] data_p2_q, data_p2_d;
   logic [1:0]           nerr_p2_q, nerr_p2_d;
   logic [CNT_WIDTH-1:0] cnt_single_q, cnt_single_d;
   logic [CNT_WIDTH-1:0] cnt_double_q, cnt_double_d;

   always_comb begin
      s2_load = !vld_p2_q || out_ready;
      s1_load = !vld_p1_q || s2_load;
   end

   assign in_ready = s1_load;
   assign cw_in    = CODEWORD_IN & cw_mask(CODEWORD_WIDTH);

   ecc_syndrome u_syn (
      .cw    (cw_in),
      .width (CODEWORD_WIDTH),
      .syn   (syn_in)
   );

   // Stage 1: masked codeword, width code and syndrome
   always_comb begin
      vld_p1_d   = s1_load ? in_valid : vld_p1_q;
      cw_p1_d    = cw_p1_q;
      width_p1_d = width_p1_q;
      syn_p1_d   = syn_p1_q;
      if (s1_load && in_valid) begin
         cw_p1_d    = cw_in;
         width_p1_d = CODEWORD_WIDTH;
         syn_p1_d   = syn_in;
      end
   end

   always_comb begin
      h_p1      = h_for(width_p1_q);
      fixed_cw  = cw_p1_q;
      corr_nerr = NERR_NONE;
      if (syn_p1_q != '0) begin
         corr_nerr = NERR_TWO;
         if (syn_p1_q[0]) begin
            for (int j = 0; j < WORD_W; j++) begin
               if (h_p1[j] == syn_p1_q) begin
                  fixed_cw[j] = ~cw_p1_q[j];
                  corr_nerr   = NERR_ONE;
               end
            end
         end
      end
      corr_data = (fixed_cw >> cw_p(width_p1_q)) & data_mask(width_p1_q);
   end

   // Stage 2: corrected data and error count
   always_comb begin
      vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
      data_p2_d = data_p2_q;
      nerr_p2_d = nerr_p2_q;
      if (s2_load && vld_p1_q) begin
         data_p2_d = corr_data;
         nerr_p2_d = corr_nerr;
      end
   end

   always_comb begin
      fire         = vld_p2_q && out_ready;
      cnt_single_d = cnt_single_q;
      cnt_double_d = cnt_double_q;
      if (cnt_clear) begin
         cnt_single_d = '0;
         cnt_double_d = '0;
      end else if (fire) begin
         if (nerr_p2_q == NERR_ONE) cnt_single_d = sat_inc(cnt_single_q);
         if (nerr_p2_q == NERR_TWO) cnt_double_d = sat_inc(cnt_double_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         data_p2_q    <= '0;
         nerr_p2_q    <= NERR_NONE;
         cnt_single_q <= '0;
         cnt_double_q <= '0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         vld_p2_q     <= vld_p2_d;
         data_p2_q    <= data_p2_d;
         nerr_p2_q    <= nerr_p2_d;
         cnt_single_q <= cnt_single_d;
         cnt_double_q <= cnt_double_d;
      end
   end

   always_ff @(posedge clk) begin
      cw_p1_q    <= cw_p1_d;
      width_p1_q <= width_p1_d;
      syn_p1_q   <= syn_p1_d;
   end

   assign out_valid      = vld_p2_q;
   assign DATA_OUT       = data_p2_q;
   assign NUM_OF_ERRORS  = nerr_p2_q;
   assign err_cnt_single = cnt_single_q;
   assign err_cnt_double = cnt_double_q;

endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: directed scoreboard bench for ecc_decoder. Stimulus pushes
// the expected result when the decoder accepts a beat; a negedge monitor pops
// and compares delivered results, tracks the expected counters and checks
// in_ready against pipeline occupancy.
module tb_ecc_decoder;
   import ecc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clear;
   logic [31:0] CODEWORD_IN, DATA_OUT;
   logic [1:0]  CODEWORD_WIDTH, NUM_OF_ERRORS;
   logic [15:0] err_cnt_single, err_cnt_double;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  nerr;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_single = '0;
   logic [15:0] m_double = '0;

   ecc_decoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .CODEWORD_IN    (CODEWORD_IN),
      .CODEWORD_WIDTH (CODEWORD_WIDTH),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .DATA_OUT       (DATA_OUT),
      .NUM_OF_ERRORS  (NUM_OF_ERRORS),
      .cnt_clear      (cnt_clear),
      .err_cnt_single (err_cnt_single),
      .err_cnt_double (err_cnt_double)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wn(input logic [1:0] w);
      return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
   endfunction

   function automatic int wp(input logic [1:0] w);
      return (w == 2'b00) ? 4 : (w == 2'b01) ? 5 : 6;
   endfunction

   function automatic logic [31:0] enc(input logic [1:0] w, input logic [31:0] d);
      int          n, p;
      hmat_t       h;
      logic [5:0]  s;
      logic [31:0] c;
      n = wn(w);
      p = wp(w);
      h = h_for(w);
      c = d << p;
      if (n < 32) c = c & ((32'd1 << n) - 32'd1);
      s = '0;
      for (int j = 0; j < 32; j++) if (c[j]) s = s ^ h[j];
      for (int i = 1; i < p; i++) c[i] = s[i];
      c[0] = ^s;
      return c;
   endfunction

   task automatic send(input logic [31:0] cw, input logic [1:0] w,
                       input logic [31:0] d, input logic [1:0] ne);
      int waited;
      exp_t e;
      waited         = 0;
      CODEWORD_IN    = cw;
      CODEWORD_WIDTH = w;
      in_valid       = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
         @(posedge clk);
         #1 in_valid = 1'b0;
      end else begin
         @(posedge clk);
         e.data = d;
         e.nerr = ne;
         q.push_back(e);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 500) begin
         @(posedge clk);
         #1 t++;
      end
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", q.size());
         q.delete();
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_single = '0;
         m_double = '0;
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !out_ready)});
         chk("err_cnt_single", {16'd0, err_cnt_single}, {16'd0, m_single});
         chk("err_cnt_double", {16'd0, err_cnt_double}, {16'd0, m_double});
         if (out_valid) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: DATA_OUT 0x%0h with empty scoreboard", DATA_OUT);
            end else begin
               chk("DATA_OUT", DATA_OUT, q[0].data);
               chk("NUM_OF_ERRORS", {30'd0, NUM_OF_ERRORS}, {30'd0, q[0].nerr});
               if (out_ready) begin
                  if (q[0].nerr == 2'd1 && m_single != 16'hFFFF) m_single++;
                  if (q[0].nerr == 2'd2 && m_double != 16'hFFFF) m_double++;
                  void'(q.pop_front());
               end
            end
         end
         if (cnt_clear) begin
            m_single = '0;
            m_double = '0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c, d;
      logic [1:0]  w;
      int          n, p, b1, b2;
      bit          stream_done;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
      CODEWORD_IN = '0; CODEWORD_WIDTH = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", DATA_OUT, 32'd0);
      chk("rst_nerr", {30'd0, NUM_OF_ERRORS}, 32'd0);
      chk("rst_cnt_single", {16'd0, err_cnt_single}, 32'd0);
      chk("rst_cnt_double", {16'd0, err_cnt_double}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Small 0xA encodes to 0xA5; upper garbage must be ignored
      send(32'h1234_56A5, 2'b00, 32'h0000_000A, 2'd0);
      chk("lat_early", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1 chk("lat_on_time", {31'd0, out_valid}, 32'd1);
      chk("t1_data", DATA_OUT, 32'h0000_000A);
      drain();

      send(enc(2'b01, 32'h5A5) ^ (32'd1 << 9), 2'b01, 32'h0000_05A5, 2'd1);
      drain();
      chk("t2_cnt_single", {16'd0, err_cnt_single}, 32'd1);

      send(enc(2'b10, 32'h2ABCDEF) ^ (32'd1 << 3) ^ (32'd1 << 20), 2'b10, 32'h02AB_8DEF, 2'd2);
      drain();
      chk("t3_cnt_double", {16'd0, err_cnt_double}, 32'd1);

      send(32'h0000_00A1, 2'b00, 32'h0000_000A, 2'd1);
      send(32'h0000_00A4, 2'b00, 32'h0000_000A, 2'd1);
      send(32'h0000_0095, 2'b00, 32'h0000_0009, 2'd2);
      send(enc(2'b11, 32'h3FF_FFFF), 2'b11, 32'h03FF_FFFF, 2'd0);
      send(enc(2'b10, 32'h123_4567) ^ 32'h8000_0000, 2'b10, 32'h0123_4567, 2'd1);
      drain();

      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               w = 2'(i % 4);
               n = wn(w);
               p = wp(w);
               d = (32'(i) * 32'd2654435 + 32'd17) & ((32'd1 << (n - p)) - 32'd1);
               c = enc(w, d);
               case (i % 3)
                  0: send(c, w, d, 2'd0);
                  1: send(c ^ (32'd1 << ((i * 7) % n)), w, d, 2'd1);
                  default: begin
                     b1 = (i * 3) % n;
                     b2 = (b1 + 1 + (i % 5)) % n;
                     c  = c ^ (32'd1 << b1) ^ (32'd1 << b2);
                     send(c, w, c >> p, 2'd2);
                  end
               endcase
            end
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk);
               #1 out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      drain();

      out_ready = 1'b0;
      send(32'h0000_00A5, 2'b00, 32'h0000_000A, 2'd0);
      send(32'h0000_00A1, 2'b00, 32'h0000_000A, 2'd1);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_cnt_single", {16'd0, err_cnt_single}, 32'd0);
      chk("mid_rst_cnt_double", {16'd0, err_cnt_double}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      send(enc(2'b01, 32'h7FF) ^ (32'd1 << 15), 2'b01, 32'h0000_07FF, 2'd1);
      drain();
      chk("post_rst_cnt_single", {16'd0, err_cnt_single}, 32'd1);

      cnt_clear = 1'b1;
      @(posedge clk);
      #1 cnt_clear = 1'b0;
      chk("clear_cnt_single", {16'd0, err_cnt_single}, 32'd0);

      for (int i = 0; i < 65535; i++) begin
         d = 32'(i % 16);
         send(enc(2'b00, d) ^ (32'd1 << (i % 8)), 2'b00, d, 2'd1);
      end
      drain();
      chk("sat_reach", {16'd0, err_cnt_single}, 32'h0000_FFFF);
      send(enc(2'b00, 32'h3) ^ 32'h40, 2'b00, 32'h3, 2'd1);
      drain();
      chk("sat_hold", {16'd0, err_cnt_single}, 32'h0000_FFFF);

      out_ready = 1'b0;
      send(enc(2'b00, 32'h6) ^ 32'h2, 2'b00, 32'h6, 2'd1);
      @(posedge clk);
      #1 chk("clr_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      cnt_clear = 1'b1;
      @(posedge clk);
      #1 cnt_clear = 1'b0;
      chk("clr_wins", {16'd0, err_cnt_single}, 32'd0);
      chk("clr_drained", {31'd0, out_valid}, 32'd0);
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
